fp16_norm_round: RTL and testbench
==================================

Name: fp16_norm_round

Overview:
- Downstream neighbour of the 11-bit leading-zero detector in the FloatAdd datapath.
- Consumes the raw adder result (carry, 11-bit mantissa, guard/round/sticky) plus the detector's zero count.
- Normalises, rounds to nearest-even and packs an IEEE binary16 word.
- Two-stage pipeline: stage 1 shifts and adjusts the exponent, stage 2 rounds and packs. Valid/ready on both sides.

Parameters:
- EXP_W, 5, exponent field width. Only the default is supported.
- MAN_W, 11, mantissa width including the hidden bit. Only the default is supported.
- LZ_W, 4, width of the leading-zero count.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts the beat this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent of the larger operand; 0..30, specials handled upstream
- in_carry  in  1  adder carry-out; weight 2^1 relative to mantissa bit 10
- in_mant  in  MAN_W  adder sum bits [10:0]
- in_grs  in  3  guard, round, sticky (bit 2 = guard)
- in_lz  in  LZ_W  leading-zero count of in_mant, 0..11; 11 means in_mant is zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  16  {sign, exp[4:0], frac[9:0]}
- out_ovf  out  1  result overflowed to infinity

Behaviour:
- Reset: asynchronous, active-low. Clears both stage valid bits, out_data = 16'h0000, out_ovf = 0.
  - Assertion mid-operation discards in-flight beats immediately.
  - in_ready is 1 from the first cycle after release.
- Handshake: a beat transfers on a side when valid && ready.
  - Stage 2 advances when it is empty or out_ready = 1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - in_ready = stage 1 advancing condition.
  - Latency is 2 cycles from input transfer to out_valid. Throughput is 1 beat per cycle.
  - out_data and out_ovf hold stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Stage 1 (normalise), priority order:
  - in_carry = 1: mant = {1, in_mant[10:1]}; g = in_mant[0]; r = grs[2]; s = grs[1] | grs[0]; exp = in_exp + 1.
  - in_carry = 0 and in_lz = 11: zero result. exp = 0, mant = 0, g = r = s = 0, sign preserved.
  - in_carry = 0 and in_lz = 0: pass through unchanged.
  - in_carry = 0, in_lz in 1..10: shift amount sh = in_lz if in_lz < in_exp, else (in_exp == 0 ? 0 : in_exp - 1).
  - Shift rule: left-shift the 13-bit word {in_mant, g, r} by sh, zero fill. mant = top 11 bits, g and r = next 2 bits, s = grs[0] unchanged.
  - Exponent: exp = in_exp - sh when in_lz < in_exp, else exp = 0 (subnormal).
- Stage 2 (round and pack):
  - round_up = g & (r | s | mant[0]); m = mant + round_up, 12 bits.
  - If m[11] = 1: frac = 0, exp = exp + 1.
  - If exp = 0 and m[10] = 1: exp = 1 (subnormal rounds into normal).
  - If final exp >= 31, including the carry path from in_exp = 30: out_data = {sign, 5'h1F, 10'h0} and out_ovf = 1.
  - Otherwise out_data = {sign, exp, m[9:0]} and out_ovf = 0.
- Width rules:
  - Exponent arithmetic is carried 1 bit wider than EXP_W, so the overflow check has no wrap-around.
  - in_lz values above 11 are illegal. Behaviour for them is unspecified but must not lock the handshake.

Test Plan:
- Left shift: in_mant = 11'b00000000101, in_lz = 8, in_exp = 20, in_grs = 0, carry 0, sign 0 -> out_data = 16'h3100, out_ovf = 0, out_valid exactly 2 cycles after transfer.
- Carry with round-up: in_carry = 1, in_mant = 11'h7FF, in_grs = 0, in_exp = 15 -> RNE round-up -> out_data = 16'h4400.
- Overflow: in_carry = 1, in_mant = 11'h400, in_exp = 30 -> out_data = 16'h7C00, out_ovf = 1.
- Subnormal and zero:
  - in_mant = 11'b00000000101, in_lz = 8, in_exp = 3 -> out_data = 16'h0014.
  - in_mant = 0, in_lz = 11, sign 1 -> out_data = 16'h8000.
- Backpressure: stream 4 beats with out_ready held low for 5 cycles.
  - in_ready drops after 2 beats are buffered.
  - out_data is held stable while out_ready is low.
  - All 4 results emerge in order once out_ready = 1.
- Reset mid-stream: assert rst_n low with both stages full -> out_valid = 0 and out_data = 0 immediately (asynchronous). No stale beat appears after release.

Source files
------------

// File: rtl/fp16_norm_round.sv
// Normalise, round-to-nearest-even and pack stage following the 11-bit LZD in the FloatAdd datapath.
// Stage 1 shifts the raw sum and adjusts the exponent; stage 2 rounds and packs a binary16 word.
module fp16_norm_round #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 11,
    parameter int LZ_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic                      in_carry,
    input  logic [MAN_W-1:0]          in_mant,
    input  logic [2:0]                in_grs,
    input  logic [LZ_W-1:0]           in_lz,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MAN_W-1:0]    out_data,
    output logic                      out_ovf
);

    localparam int EW = EXP_W + 1;
    localparam int OW = EXP_W + MAN_W;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [EW-1:0]    s1_exp_q, s1_exp_d;
    logic [MAN_W-1:0] s1_mant_q, s1_mant_d;
    logic             s1_g_q, s1_g_d;
    logic             s1_r_q, s1_r_d;
    logic             s1_s_q, s1_s_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic             s1_adv, s2_adv;
    logic             lz_lt_exp;
    logic [LZ_W-1:0]  sh;
    logic [MAN_W+1:0] sh_word;
    logic             n1_sign;
    logic [EW-1:0]    n1_exp;
    logic [MAN_W-1:0] n1_mant;
    logic             n1_g, n1_r, n1_s;

    logic             round_up;
    logic [MAN_W:0]   m_rnd;
    logic [EW-1:0]    e_rnd;
    logic             ovf;
    logic [OW-1:0]    packed_word;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Stage 1: normalise. Shift is clamped so the exponent never goes below the subnormal floor.
    always_comb begin
        n1_sign   = in_sign;
        n1_exp    = '0;
        n1_mant   = '0;
        n1_g      = 1'b0;
        n1_r      = 1'b0;
        n1_s      = 1'b0;
        sh        = '0;
        sh_word   = '0;
        lz_lt_exp = ({{(EW-LZ_W){1'b0}}, in_lz} < {1'b0, in_exp});
        if (in_carry) begin
            n1_mant = {1'b1, in_mant[MAN_W-1:1]};
            n1_g    = in_mant[0];
            n1_r    = in_grs[2];
            n1_s    = in_grs[1] | in_grs[0];
            n1_exp  = {1'b0, in_exp} + EW'(1);
        end else if (in_lz >= LZ_W'(MAN_W)) begin
            // zero result (codes above 11 are illegal and folded in here)
            n1_exp = '0;
        end else if (in_lz == '0) begin
            n1_mant = in_mant;
            n1_g    = in_grs[2];
            n1_r    = in_grs[1];
            n1_s    = in_grs[0];
            n1_exp  = {1'b0, in_exp};
        end else begin
            if (lz_lt_exp) begin
                sh = in_lz;
            end else if (in_exp == '0) begin
                sh = '0;
            end else begin
                sh = LZ_W'(in_exp - EXP_W'(1));
            end
            sh_word = {in_mant, in_grs[2:1]} << sh;
            n1_mant = sh_word[MAN_W+1:2];
            n1_g    = sh_word[1];
            n1_r    = sh_word[0];
            n1_s    = in_grs[0];
            n1_exp  = lz_lt_exp ? ({1'b0, in_exp} - EW'(sh)) : '0;
        end
    end

    // Stage 2: round to nearest even and pack; exponent kept one bit wide so overflow is visible.
    always_comb begin
        round_up = s1_g_q & (s1_r_q | s1_s_q | s1_mant_q[0]);
        m_rnd    = {1'b0, s1_mant_q} + {{MAN_W{1'b0}}, round_up};
        e_rnd    = s1_exp_q;
        if (m_rnd[MAN_W]) begin
            e_rnd = s1_exp_q + EW'(1);
        end
        if ((e_rnd == '0) && m_rnd[MAN_W-1]) begin
            e_rnd = EW'(1);
        end
        ovf = (e_rnd >= EW'((1 << EXP_W) - 1));
        if (ovf) begin
            packed_word = {s1_sign_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        end else begin
            packed_word = {s1_sign_q, e_rnd[EXP_W-1:0], m_rnd[MAN_W-2:0]};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s1_g_d     = s1_g_q;
        s1_r_d     = s1_r_q;
        s1_s_d     = s1_s_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = n1_sign;
                s1_exp_d  = n1_exp;
                s1_mant_d = n1_mant;
                s1_g_d    = n1_g;
                s1_r_d    = n1_r;
                s1_s_d    = n1_s;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = packed_word;
                out_ovf_d  = ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_g_q     <= 1'b0;
            s1_r_q     <= 1'b0;
            s1_s_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s1_g_q     <= s1_g_d;
            s1_r_q     <= s1_r_d;
            s1_s_q     <= s1_s_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Bench for fp16_norm_round: directed spot values, handshake scenarios and a random stream
// scored against an integer-arithmetic model of normalise/round/pack.
module tb_fp16_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = '0;
    logic        in_carry = 1'b0;
    logic [10:0] in_mant = '0;
    logic [2:0]  in_grs = '0;
    logic [3:0]  in_lz = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        sign;
        logic [4:0]  exp;
        logic        carry;
        logic [10:0] mant;
        logic [2:0]  grs;
        logic [3:0]  lz;
    } beat_t;

    always #5 clk = ~clk;

    fp16_norm_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_carry(in_carry),
        .in_mant(in_mant), .in_grs(in_grs), .in_lz(in_lz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    // Returns {ovf, data}, computed with integer arithmetic on the numeric fields.
    function automatic logic [16:0] ref_model(beat_t b);
        int mant, e, m, g, r, s, sh, w, gv, rv, sv;
        mant = int'(b.mant);
        gv = int'(b.grs[2]); rv = int'(b.grs[1]); sv = int'(b.grs[0]);
        if (b.carry) begin
            m = 1024 + mant / 2; g = mant % 2; r = gv; s = (rv + sv > 0) ? 1 : 0;
            e = int'(b.exp) + 1;
        end else if (int'(b.lz) >= 11) begin
            m = 0; g = 0; r = 0; s = 0; e = 0;
        end else if (b.lz == 0) begin
            m = mant; g = gv; r = rv; s = sv; e = int'(b.exp);
        end else begin
            if (int'(b.lz) < int'(b.exp)) sh = int'(b.lz);
            else if (b.exp == 0) sh = 0;
            else sh = int'(b.exp) - 1;
            w = ((mant * 4 + gv * 2 + rv) * (1 << sh)) % 8192;
            m = w / 4; g = (w / 2) % 2; r = w % 2; s = sv;
            e = (int'(b.lz) < int'(b.exp)) ? int'(b.exp) - sh : 0;
        end
        if (g == 1 && (r == 1 || s == 1 || m % 2 == 1)) m = m + 1;
        if (m >= 2048) begin
            m = 0; e = e + 1;
        end
        if (e == 0 && m >= 1024) e = 1;
        if (e >= 31) return {1'b1, b.sign, 5'h1F, 10'h000};
        return {1'b0, b.sign, 5'(e), 10'(m % 1024)};
    endfunction

    function automatic beat_t gen_beat();
        beat_t b;
        int k, top;
        b.sign  = 1'($urandom_range(0, 1));
        b.exp   = 5'($urandom_range(0, 30));
        b.grs   = 3'($urandom_range(0, 7));
        b.carry = ($urandom_range(0, 3) == 0);
        if (b.carry) begin
            b.mant = 11'($urandom_range(0, 2047));
            b.lz = 4'd0;
            for (int i = 10; i >= 0; i--) begin
                if (b.mant[i]) break;
                b.lz = b.lz + 4'd1;
            end
        end else begin
            k = $urandom_range(0, 11);
            top = (k == 11) ? 0 : (1024 >> k);
            b.mant = (k == 11) ? 11'd0 : 11'(top + $urandom_range(0, top - 1));
            b.lz = 4'(k);
        end
        return b;
    endfunction

    task automatic drive(beat_t b);
        in_sign = b.sign; in_exp = b.exp; in_carry = b.carry;
        in_mant = b.mant; in_grs = b.grs; in_lz = b.lz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        n_checks++;
        if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        beat_t       vec[10];
        logic [15:0] want_d[10];
        logic        want_o[10];
        vec[0] = '{1'b0, 5'd20, 1'b0, 11'h005, 3'b000, 4'd8};  want_d[0] = 16'h3100; want_o[0] = 1'b0;
        vec[1] = '{1'b0, 5'd15, 1'b1, 11'h7FF, 3'b000, 4'd0};  want_d[1] = 16'h4400; want_o[1] = 1'b0;
        vec[2] = '{1'b0, 5'd30, 1'b1, 11'h400, 3'b000, 4'd0};  want_d[2] = 16'h7C00; want_o[2] = 1'b1;
        vec[3] = '{1'b0, 5'd3,  1'b0, 11'h005, 3'b000, 4'd8};  want_d[3] = 16'h0014; want_o[3] = 1'b0;
        vec[4] = '{1'b1, 5'd10, 1'b0, 11'h000, 3'b000, 4'd11}; want_d[4] = 16'h8000; want_o[4] = 1'b0;
        vec[5] = '{1'b0, 5'd1,  1'b0, 11'h3FF, 3'b100, 4'd1};  want_d[5] = 16'h0400; want_o[5] = 1'b0;
        vec[6] = '{1'b0, 5'd15, 1'b0, 11'h400, 3'b100, 4'd0};  want_d[6] = 16'h3C00; want_o[6] = 1'b0;
        vec[7] = '{1'b0, 5'd15, 1'b0, 11'h401, 3'b100, 4'd0};  want_d[7] = 16'h3C02; want_o[7] = 1'b0;
        vec[8] = '{1'b0, 5'd30, 1'b0, 11'h7FF, 3'b100, 4'd0};  want_d[8] = 16'h7C00; want_o[8] = 1'b1;
        vec[9] = '{1'b1, 5'd10, 1'b1, 11'h001, 3'b011, 4'd10}; want_d[9] = 16'hAC01; want_o[9] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vec[i]); in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_latency_early got out_valid=%b want 0", i, out_valid); end
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got out_valid=%b want 1", i, out_valid); end
            n_checks++;
            if (out_data !== want_d[i]) begin n_fail++; $display("FAIL dir%0d_data got %h want %h", i, out_data, want_d[i]); end
            n_checks++;
            if (out_ovf !== want_o[i]) begin n_fail++; $display("FAIL dir%0d_ovf got %b want %b", i, out_ovf, want_o[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        beat_t       beats[4];
        logic [16:0] exp_q[$];
        logic [16:0] want;
        logic [15:0] held_d;
        logic        held_o;
        logic        prev_stall;
        int          sent, recv;
        for (int i = 0; i < 4; i++) beats[i] = gen_beat();
        sent = 0; recv = 0; prev_stall = 1'b0; held_d = '0; held_o = 1'b0;
        for (int c = 0; c < 30 && recv < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid = (sent < 4);
            if (sent < 4) drive(beats[sent]);
            #1;
            if (c == 2) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0 (sent=%0d)", in_ready, sent); end
            end
            if (prev_stall) begin
                n_checks++;
                if (out_data !== held_d || out_ovf !== held_o) begin
                    n_fail++; $display("FAIL bp_hold got %h/%b want %h/%b", out_data, out_ovf, held_d, held_o);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(beats[sent])); sent++;
            end
            if (out_valid && out_ready) begin
                want = exp_q.pop_front();
                n_checks++;
                if ({out_ovf, out_data} !== want) begin
                    n_fail++; $display("FAIL bp_result%0d got %b/%h want %b/%h", recv, out_ovf, out_data, want[16], want[15:0]);
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            held_d = out_data; held_o = out_ovf;
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", recv); end
    endtask

    task automatic test_random();
        localparam int N = 400;
        beat_t       cur;
        logic [16:0] exp_q[$];
        logic [16:0] want;
        logic [15:0] held_d;
        logic        held_o;
        logic        prev_stall;
        int          sent, recv;
        sent = 0; recv = 0; prev_stall = 1'b0; held_d = '0; held_o = 1'b0;
        cur = gen_beat();
        for (int c = 0; c < 5000 && recv < N; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid = (sent < N) && ($urandom_range(0, 3) != 0);
            drive(cur);
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_data !== held_d || out_ovf !== held_o) begin
                    n_fail++; $display("FAIL rnd_hold got %h/%b want %h/%b", out_data, out_ovf, held_d, held_o);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(cur)); sent++;
                cur = gen_beat();
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra got %h want no beat", out_data);
                end else begin
                    want = exp_q.pop_front();
                    if ({out_ovf, out_data} !== want) begin
                        n_fail++; $display("FAIL rnd_result%0d got %b/%h want %b/%h", recv, out_ovf, out_data, want[16], want[15:0]);
                    end
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            held_d = out_data; held_o = out_ovf;
        end
        in_valid = 1'b0;
        n_checks++;
        if (recv !== N) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", recv, N); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        drive(beat_t'{1'b0, 5'd20, 1'b0, 11'h005, 3'b000, 4'd8});
        @(negedge clk);
        drive(beat_t'{1'b1, 5'd15, 1'b1, 11'h7FF, 3'b000, 4'd0});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_full got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000 || out_ovf !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_out_data got %h/%b want 0000/0", out_data, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cycle %0d got out_valid=%b want 0", c, out_valid); end
        end
    endtask

    task automatic test_illegal_lz();
        int seen;
        for (int v = 12; v < 16; v++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1;
            drive(beat_t'{1'b0, 5'd12, 1'b0, 11'h155, 3'b101, 4'(v)});
            @(negedge clk);
            in_valid = 1'b0;
            seen = 0;
            for (int c = 0; c < 8 && seen == 0; c++) begin
                #1;
                if (out_valid === 1'b1) seen = 1;
                @(negedge clk);
            end
            #1;
            n_checks++;
            if (seen != 1 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL illegal_lz%0d got seen=%0d in_ready=%b want 1/1", v, seen, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_illegal_lz();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
